// File: rtl/blinking_display.sv
// blinking_display
// Blink gate for an active-low anode bus. When blink is high, every anode is
// forced high (all digits dark) during alternate half-cycles of a slow,
// asynchronous clk_1hz timebase. When blink is low, anode_in passes straight
// through. clk_1hz is synchronised into clk. blink_state is toggled on each
// synchronised rising edge of clk_1hz, so the visible and blank phases each
// last one full clk_1hz period.

module blinking_display #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] anode_in,
    input  logic             blink,
    input  logic             clk_1hz,
    output logic [WIDTH-1:0] anode_out
);

    // Synchroniser chain. Bit 0 samples the asynchronous input, and the top
    // bit is the safe synchronised level.
    logic [SYNC_STAGES-1:0] r_sync;
    // Previous synchronised level, used for rising-edge detection.
    logic                   r_tick_d;
    // Blink phase. The name is kept unprefixed so that it can be observed
    // hierarchically as blink_state.
    logic                   blink_state;

    logic                   w_tick_s;
    logic                   w_rise;

    assign w_tick_s = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_tick_s & ~r_tick_d;

    // Shift the asynchronous clk_1hz level through the synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_1hz};
        end
    end

    // Remember the last synchronised level so that edges can be detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= w_tick_s;
        end
    end

    // Toggle the blink phase on each rising edge of the timebase.
    // This runs whether or not blink is set, so the phase stays locked to the timebase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_state <= 1'b0;
        end else if (w_rise) begin
            blink_state <= ~blink_state;
        end
    end

    // Blank every digit in the blink phase. Otherwise pass anode_in through with no latency.
    always_comb begin
        anode_out = anode_in;
        if (blink && blink_state) begin
            anode_out = '1;
        end
    end

endmodule

// File: tb/tb_blinking_display.sv
// tb_blinking_display
// A scoreboard bench for blinking_display. The stimulus process drives the
// inputs once per cycle, shortly after each rising clk edge. For each cycle it
// pushes the expected anode_out and blink_state, taken from a reference model.
// A separate monitor pops one entry on each falling edge and compares it.
//
// The reference model uses only the stated timing: a clk_1hz rise first seen
// at clk edge n flips the blink phase at edge n+2. During reset the phase is
// zero. The output is all ones when blink and the phase are both high, and
// anode_in otherwise.

module tb_blinking_display;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] anode_in;
    logic         blink;
    logic         clk_1hz;
    logic [W-1:0] anode_out;

    blinking_display #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .anode_in (anode_in),
        .blink    (blink),
        .clk_1hz  (clk_1hz),
        .anode_out(anode_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] anode;
        logic         state;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    int   m_cyc = 0;
    logic m_state = 1'b0;
    logic m_prev = 1'b0;
    int   m_due[$];
    int   hz_cnt = 0;

    // Advance the model at each clk edge, using the input levels seen at that edge.
    always @(posedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            m_state = 1'b0;
            m_prev  = 1'b0;
            m_due.delete();
        end else begin
            while (m_due.size() != 0 && m_due[0] == m_cyc) begin
                m_state = ~m_state;
                void'(m_due.pop_front());
            end
            if (clk_1hz && !m_prev) m_due.push_back(m_cyc + 2);
            m_prev = clk_1hz;
        end
    end

    // Monitor: compare the DUT outputs against the oldest expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (anode_out !== mon_e.anode) begin
                errors++;
                $display("FAIL anode_out got %b exp %b at %0t", anode_out, mon_e.anode, $time);
            end
            checks++;
            if (dut.blink_state !== mon_e.state) begin
                errors++;
                $display("FAIL blink_state got %b exp %b at %0t", dut.blink_state, mon_e.state, $time);
            end
        end
    end

    // Count blink_state changes observed on the DUT.
    int   dut_toggles = 0;
    logic last_bs = 1'b0;
    always @(negedge clk) begin
        if (dut.blink_state !== last_bs) dut_toggles++;
        last_bs = dut.blink_state;
    end

    task automatic push_exp();
        exp_t e;
        e.state = rst_n ? m_state : 1'b0;
        e.anode = (blink && e.state) ? {W{1'b1}} : anode_in;
        sb_q.push_back(e);
    endtask

    // Return the next level of a 1000 ns square wave (toggle every 50 cycles).
    task automatic periodic_hz(output logic hz);
        hz = clk_1hz;
        hz_cnt++;
        if (hz_cnt >= 50) begin
            hz     = ~clk_1hz;
            hz_cnt = 0;
        end
    endtask

    // Apply one cycle of stimulus just after the active edge, then record the expectation.
    task automatic apply(input logic b, input logic [W-1:0] a, input logic r, input logic hz);
        @(posedge clk);
        #2;
        blink    = b;
        anode_in = a;
        rst_n    = r;
        clk_1hz  = hz;
        push_exp();
    endtask

    task automatic run_periodic(input int n, input logic b, input logic [W-1:0] a);
        logic hz;
        for (int i = 0; i < n; i++) begin
            periodic_hz(hz);
            apply(b, a, 1'b1, hz);
        end
    endtask

    // Run periodic cycles until the model phase equals want. A timeout counts as a failure.
    task automatic wait_phase(input logic want, input logic b, input logic [W-1:0] a);
        logic hz;
        int   i;
        for (i = 0; i < 300 && m_state !== want; i++) begin
            periodic_hz(hz);
            apply(b, a, 1'b1, hz);
        end
        if (m_state !== want) begin
            checks++;
            errors++;
            $display("FAIL phase_wait got %b exp %b (timeout)", m_state, want);
        end
    endtask

    initial begin
        logic hz;
        int   t0;

        // Reset with pass-through.
        rst_n    = 1'b1;
        blink    = 1'b0;
        anode_in = 4'b1010;
        clk_1hz  = 1'b0;
        #1 rst_n = 1'b0;
        push_exp();
        #11 rst_n = 1'b1;
        run_periodic(20, 1'b0, 4'b1010);

        // Blink on, then alternate between the visible and blank phases.
        run_periodic(200, 1'b1, 4'b1010);

        // Blink off during a blank phase restores the digits at once.
        wait_phase(1'b1, 1'b1, 4'b1010);
        run_periodic(3, 1'b0, 4'b1010);
        run_periodic(120, 1'b0, 4'b1010);

        // Blink on with a new pattern.
        run_periodic(150, 1'b1, 4'b0101);

        // Asynchronous reset in the middle of a blank phase.
        wait_phase(1'b1, 1'b1, 4'b0101);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        push_exp();
        #1;
        checks++;
        if (anode_out !== 4'b0101 || dut.blink_state !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %b/%b exp 0101/0", anode_out, dut.blink_state);
        end
        apply(1'b1, 4'b0101, 1'b0, clk_1hz);
        apply(1'b1, 4'b0101, 1'b1, clk_1hz);

        // Hold clk_1hz high: expect exactly one toggle after the rise.
        for (int i = 0; i < 5; i++) apply(1'b1, 4'b0110, 1'b1, 1'b0);
        t0 = dut_toggles;
        for (int i = 0; i < 500; i++) apply(1'b1, 4'b0110, 1'b1, 1'b1);
        checks++;
        if (dut_toggles - t0 != 1) begin
            errors++;
            $display("FAIL hold_toggles got %0d exp 1", dut_toggles - t0);
        end

        // Randomised stimulus.
        hz = clk_1hz;
        for (int i = 0; i < 2500; i++) begin
            logic         b;
            logic [W-1:0] a;
            logic         r;
            b = ($urandom_range(0, 19) == 0) ? ~blink : blink;
            a = ($urandom_range(0, 3) == 0) ? W'($urandom) : anode_in;
            r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 24) == 0) hz = ~hz;
            apply(b, a, r, hz);
        end
        apply(blink, anode_in, 1'b1, hz);

        // Drain the scoreboard, waiting at most a few cycles.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending exp 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
